food_box_gen: RTL and testbench

- Responder to the snake body's `create_new_box` request.
- On each request, picks a new pseudo-random 10-pixel-aligned food box position that is on screen and not on the snake head.
- Holds `box_x`/`box_y` stable for the snake body's collision check.
- Drives the box pixel for the VGA mux and keeps a saturating eaten count for the score display.

---
 rtl/food_box_gen.sv | 163 ++++++++++++++++
 tb/tb_food_box_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_box_gen.sv
// Food box generator: on each create_new_box request, draws LFSR candidates until one is on screen and off the snake head.
// Result lands 3 cycles after the request (+2 per rejection, fallback cell after MAX_TRIES); requests while busy are dropped.
module food_box_gen #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          INIT_X     = 200,
    parameter int          INIT_Y     = 200,
    parameter int          MAX_TRIES  = 8,
    parameter int          FALLBACK_X = 320,
    parameter int          FALLBACK_Y = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       create_new_box,
    input  logic [9:0] head_x,
    input  logic [8:0] head_y,
    input  logic [9:0] x_pos,
    input  logic [8:0] y_pos,
    output logic [9:0] box_x,
    output logic [8:0] box_y,
    output logic       busy,
    output logic [7:0] eaten_count,
    output logic       box_vga
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [3:0]  MAX_T = 4'(MAX_TRIES);
    localparam logic [5:0]  FB_CX = 6'(FALLBACK_X / 10);
    localparam logic [5:0]  FB_CY = 6'(FALLBACK_Y / 10);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  tries_q, tries_d;
    logic [5:0]  cx_q, cx_d;
    logic [5:0]  cy_q, cy_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [8:0]  box_y_q, box_y_d;
    logic        busy_q, busy_d;
    logic [7:0]  eaten_q, eaten_d;

    logic [9:0]  cand_x10;
    logic [8:0]  cand_y10;
    logic        cand_ok;
    logic        fb_on_head;
    logic [3:0]  tries_inc;
    logic [10:0] box_x_end;
    logic [9:0]  box_y_end;

    // Cell-to-pixel scaling by shift-and-add; y wraps only for off-screen rows, which are rejected anyway.
    function automatic logic [9:0] times10_x(input logic [5:0] c);
        return ({4'b0, c} << 3) + ({4'b0, c} << 1);
    endfunction

    function automatic logic [8:0] times10_y(input logic [5:0] c);
        return ({3'b0, c} << 3) + ({3'b0, c} << 1);
    endfunction

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q == 16'd0) begin
            lfsr_d = SEED;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end
    end

    assign cand_x10   = times10_x(cx_q);
    assign cand_y10   = times10_y(cy_q);
    assign cand_ok    = (cy_q < 6'd48) && !((cand_x10 == head_x) && (cand_y10 == head_y));
    assign fb_on_head = (times10_x(FB_CX) == head_x) && (times10_y(FB_CY) == head_y);
    assign tries_inc  = tries_q + 4'd1;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        busy_d  = busy_q;
        eaten_d = eaten_q;
        case (state_q)
            IDLE: begin
                if (create_new_box) begin
                    state_d = DRAW;
                    busy_d  = 1'b1;
                    tries_d = 4'd0;
                end
            end
            DRAW: begin
                cx_d    = lfsr_q[5:0];
                cy_d    = lfsr_q[11:6];
                state_d = CHECK;
            end
            CHECK: begin
                if (cand_ok) begin
                    state_d = COMMIT;
                end else begin
                    tries_d = tries_inc;
                    if (tries_inc == MAX_T) begin
                        cx_d    = fb_on_head ? 6'd0 : FB_CX;
                        cy_d    = fb_on_head ? 6'd0 : FB_CY;
                        state_d = COMMIT;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            COMMIT: begin
                box_x_d = cand_x10;
                box_y_d = cand_y10;
                eaten_d = (eaten_q == 8'hFF) ? eaten_q : eaten_q + 8'd1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            tries_q <= 4'd0;
            cx_q    <= 6'd0;
            cy_q    <= 6'd0;
            box_x_q <= 10'(INIT_X);
            box_y_q <= 9'(INIT_Y);
            busy_q  <= 1'b0;
            eaten_q <= 8'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tries_q <= tries_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            busy_q  <= busy_d;
            eaten_q <= eaten_d;
        end
    end

    // Box edges are exclusive on both sides to line up with the snake renderer.
    assign box_x_end = {1'b0, box_x_q} + 11'd10;
    assign box_y_end = {1'b0, box_y_q} + 10'd10;
    assign box_vga   = (x_pos > box_x_q) && ({1'b0, x_pos} < box_x_end) &&
                       (y_pos > box_y_q) && ({1'b0, y_pos} < box_y_end);

    assign box_x       = box_x_q;
    assign box_y       = box_y_q;
    assign busy        = busy_q;
    assign eaten_count = eaten_q;

endmodule

// File: tb/tb_food_box_gen.sv
// Bench for food_box_gen: reference model predicts each request's outcome from the LFSR sequence and the head.
// Two instances: default MAX_TRIES=8, and MAX_TRIES=1 for the fallback paths.
module tb_food_box_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [9:0] hx1 = '0, hx2 = '0;
    logic [8:0] hy1 = '0, hy2 = '0;
    logic [9:0] x_pos = '0;
    logic [8:0] y_pos = '0;
    logic       vga_manual = 1'b1;

    logic [9:0] bx1, bx2;
    logic [8:0] by1, by2;
    logic       busy1, busy2, vga1, vga2;
    logic [7:0] eat1, eat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    food_box_gen dut1 (
        .clk(clk), .rst(rst), .create_new_box(req1), .head_x(hx1), .head_y(hy1),
        .x_pos(x_pos), .y_pos(y_pos), .box_x(bx1), .box_y(by1), .busy(busy1),
        .eaten_count(eat1), .box_vga(vga1)
    );

    food_box_gen #(.MAX_TRIES(1)) dut2 (
        .clk(clk), .rst(rst), .create_new_box(req2), .head_x(hx2), .head_y(hy2),
        .x_pos(x_pos), .y_pos(y_pos), .box_x(bx2), .box_y(by2), .busy(busy2),
        .eaten_count(eat2), .box_vga(vga2)
    );

    typedef struct packed {
        logic [9:0] bx;
        logic [8:0] by;
        logic [5:0] ncyc;
    } pred_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s: condition got %b, expected 1", name, cond);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        if (l == 16'd0) return 16'hACE1;
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    // Whole-request outcome: candidate k is the LFSR value 2k steps after the request edge.
    function automatic pred_t predict(input logic [15:0] l_post, input logic [9:0] hx,
                                      input logic [8:0] hy, input int maxt);
        pred_t       p;
        logic [15:0] l;
        int          cx, cy;
        l = l_post;
        for (int k = 0; k < maxt; k++) begin
            cx = int'(l[5:0]);
            cy = int'(l[11:6]);
            if (cy < 48 && !(cx * 10 == int'(hx) && cy * 10 == int'(hy))) begin
                p.bx   = 10'(cx * 10);
                p.by   = 9'(cy * 10);
                p.ncyc = 6'(3 + 2 * k);
                return p;
            end
            l = lfsr_step(lfsr_step(l));
        end
        if (int'(hx) == 320 && int'(hy) == 240) begin
            p.bx = 10'd0;
            p.by = 9'd0;
        end else begin
            p.bx = 10'd320;
            p.by = 9'd240;
        end
        p.ncyc = 6'(1 + 2 * maxt);
        return p;
    endfunction

    function automatic logic vga_exp(input logic [9:0] bx, input logic [8:0] by,
                                     input logic [9:0] x, input logic [8:0] y);
        return (int'(x) > int'(bx)) && (int'(x) < int'(bx) + 10) &&
               (int'(y) > int'(by)) && (int'(y) < int'(by) + 10);
    endfunction

    logic [15:0] m_lfsr;
    logic [9:0]  m_bx[2];
    logic [8:0]  m_by[2];
    logic        m_busy[2];
    logic [7:0]  m_eat[2];
    pred_t       m_pred[2];
    int          m_cnt[2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            for (int i = 0; i < 2; i++) begin
                m_bx[i]   <= 10'd200;
                m_by[i]   <= 9'd200;
                m_busy[i] <= 1'b0;
                m_eat[i]  <= 8'd0;
                m_pred[i] <= '0;
                m_cnt[i]  <= 0;
            end
        end else begin
            m_lfsr <= lfsr_step(m_lfsr);
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    if (m_cnt[i] + 1 == int'(m_pred[i].ncyc)) begin
                        m_busy[i] <= 1'b0;
                        m_bx[i]   <= m_pred[i].bx;
                        m_by[i]   <= m_pred[i].by;
                        m_eat[i]  <= (m_eat[i] == 8'd255) ? 8'd255 : m_eat[i] + 8'd1;
                    end
                    m_cnt[i] <= m_cnt[i] + 1;
                end else if ((i == 0) ? req1 : req2) begin
                    m_busy[i] <= 1'b1;
                    m_cnt[i]  <= 0;
                    m_pred[i] <= predict(lfsr_step(m_lfsr), (i == 0) ? hx1 : hx2,
                                         (i == 0) ? hy1 : hy2, (i == 0) ? 8 : 1);
                end
            end
        end
    end

    int blen1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            chk("box_x", bx1, m_bx[0]);
            chk("box_y", by1, m_by[0]);
            chk("busy", busy1, m_busy[0]);
            chk("eaten", eat1, m_eat[0]);
            chk("box_vga", vga1, vga_exp(m_bx[0], m_by[0], x_pos, y_pos));
            chk("box_x_mt1", bx2, m_bx[1]);
            chk("box_y_mt1", by2, m_by[1]);
            chk("busy_mt1", busy2, m_busy[1]);
            chk("eaten_mt1", eat2, m_eat[1]);
            chk("box_vga_mt1", vga2, vga_exp(m_bx[1], m_by[1], x_pos, y_pos));
            if (busy1) begin
                chk_true("busy_max17", blen1 < 17);
                blen1 <= blen1 + 1;
            end else begin
                blen1 <= 0;
            end
        end else begin
            blen1 <= 0;
        end
    end

    // Pixel probe wanders around one of the two boxes so the edges get exercised.
    always @(posedge clk) begin
        #1;
        if (!vga_manual) begin
            int sel;
            sel   = int'($urandom_range(0, 1));
            x_pos = 10'(int'(m_bx[sel]) + int'($urandom_range(0, 12)) - 1);
            y_pos = 9'(int'(m_by[sel]) + int'($urandom_range(0, 12)) - 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse1();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
    endtask

    task automatic pulse2();
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
    endtask

    task automatic wait_idle(input int which, input string name);
        int n;
        n = 0;
        while (((which == 1) ? busy1 : busy2) !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk_true(name, n < 40);
    endtask

    task automatic check_grid(input string pfx);
        chk({pfx, "_x_mod10"}, bx1 % 10, 0);
        chk({pfx, "_y_mod10"}, by1 % 10, 0);
        chk_true({pfx, "_in_range"}, bx1 <= 10'd630 && by1 <= 9'd470);
        chk_true({pfx, "_not_head"}, !(bx1 == hx1 && by1 == hy1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pred_t       p;
        logic [15:0] c;
        int          bl, n, moves;
        logic [9:0]  old_x;
        logic [8:0]  old_y;

        // Hand-worked model pins: ACE1 -> E270 -> 7138; first cell (33,51) off screen, second (56,4).
        p = predict(16'hACE1, 10'd400, 9'd400, 8);
        chk("pin_pred_x", p.bx, 560);
        chk("pin_pred_y", p.by, 40);
        chk("pin_pred_cyc", p.ncyc, 5);
        p = predict(16'hACE1, 10'd400, 9'd400, 1);
        chk("pin_fb_x", p.bx, 320);
        chk("pin_fb_y", p.by, 240);
        p = predict(16'hACE1, 10'd320, 9'd240, 1);
        chk("pin_fb00", {22'd0, p.bx}, 0);

        // Test 1: reset values and box pixel edges
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_box_x", bx1, 200);
        chk("rst_box_y", by1, 200);
        chk("rst_busy", busy1, 0);
        chk("rst_eaten", eat1, 0);
        tick();
        chk("model_lfsr1", m_lfsr, 16'hE270);
        tick();
        chk("model_lfsr2", m_lfsr, 16'h7138);
        x_pos = 10'd205; y_pos = 9'd205; #1;
        chk("vga_inside", vga1, 1);
        x_pos = 10'd200; #1;
        chk("vga_left_edge", vga1, 0);
        x_pos = 10'd210; #1;
        chk("vga_right_edge", vga1, 0);
        x_pos = 10'd209; y_pos = 9'd209; #1;
        chk("vga_corner", vga1, 1);
        tick();
        vga_manual = 1'b0;

        // Test 2: single request, head at (400,400)
        hx1 = 10'd400; hy1 = 9'd400;
        pulse1();
        bl = 0;
        while (busy1 === 1'b1 && bl < 40) begin
            tick();
            bl++;
        end
        chk_true("t2_busy_ge3", bl >= 3 && bl < 40);
        check_grid("t2");
        chk("t2_eaten", eat1, 1);

        // Test 3: second request one cycle later is dropped
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pulse1();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        wait_idle(1, "t3_timeout");
        tick();
        chk("t3_eaten", eat1, 1);

        // Test 6: asynchronous reset while in CHECK
        pulse1();
        tick();
        #1 rst = 1'b0;
        #1;
        chk("t6_box_x", bx1, 200);
        chk("t6_box_y", by1, 200);
        chk("t6_busy", busy1, 0);
        chk("t6_eaten", eat1, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        pulse1();
        wait_idle(1, "t6_timeout");
        chk("t6_eaten_after", eat1, 1);
        check_grid("t6");

        // Test 5: single-try instance, head forced onto the candidate
        for (int r = 0; r < 4; r++) begin
            c = lfsr_step(m_lfsr);
            n = 0;
            while (c[5:0] == 6'd32 && c[11:6] == 6'd24 && n < 10) begin
                tick();
                c = lfsr_step(m_lfsr);
                n++;
            end
            hx2 = 10'(int'(c[5:0]) * 10);
            hy2 = 9'(int'(c[11:6]) * 10);
            pulse2();
            wait_idle(2, "t5_timeout");
            tick();
            chk("t5_fb_x", bx2, 320);
            chk("t5_fb_y", by2, 240);
        end
        hx2 = 10'd320; hy2 = 9'd240;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            c = lfsr_step(m_lfsr);
            while (c[11:6] < 6'd48 && n < 200) begin
                tick();
                c = lfsr_step(m_lfsr);
                n++;
            end
            chk_true("t5_find_offscreen", n < 200);
            pulse2();
            wait_idle(2, "t5b_timeout");
            tick();
            chk("t5_zero_x", bx2, 0);
            chk("t5_zero_y", by2, 0);
        end

        // Test 4: long run, head chasing the box, counter saturation
        moves = 0;
        for (int r = 0; r < 2000; r++) begin
            hx1   = m_bx[0];
            hy1   = m_by[0];
            old_x = bx1;
            old_y = by1;
            n     = int'(eat1);
            pulse1();
            repeat (19) tick();
            check_grid("t4");
            if (n == 255 && (bx1 != old_x || by1 != old_y)) moves++;
        end
        chk("t4_eaten_sat", eat1, 255);
        chk_true("t4_moves_after_sat", moves > 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
